// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared defaults and entry layout for the reorder-buffer entry table.
package rob_pkg;

    localparam int ROB_SIZE_DEF = 8;
    localparam int REG_W_DEF    = 5;
    localparam int DATA_W_DEF   = 32;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  exc;
        logic                  has_dest;
        logic [REG_W_DEF-1:0]  dest;
        logic [DATA_W_DEF-1:0] data;
    } rob_entry_t;

    // Fresh entry from dispatch; data is left as-is since nothing reads it until writeback.
    function automatic rob_entry_t entry_alloc(input rob_entry_t old,
                                               input logic has_dest,
                                               input logic [REG_W_DEF-1:0] dest);
        rob_entry_t e;
        e          = old;
        e.valid    = 1'b1;
        e.done     = 1'b0;
        e.exc      = 1'b0;
        e.has_dest = has_dest;
        e.dest     = dest;
        return e;
    endfunction

endpackage

// File: rtl/rob_entry_table_if.sv
// rtl/rob_entry_table_if.sv - dispatch, writeback, pointer and commit signals of the ROB entry table.
interface rob_entry_table_if #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
);
    logic              alloc_valid_i;
    logic [ADDR_W-1:0] alloc_idx_i;
    logic              alloc_has_dest_i;
    logic [REG_W-1:0]  alloc_dest_i;
    logic              stall_i;
    logic              wb_valid_i;
    logic [ADDR_W-1:0] wb_idx_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              wb_exc_i;
    logic [ADDR_W-1:0] head_i;
    logic              commit_ready_i;
    logic              commit_valid_o;
    logic              commit_has_dest_o;
    logic [REG_W-1:0]  commit_dest_o;
    logic [DATA_W-1:0] commit_data_o;
    logic              commit_exc_o;
    logic              update_head_o;
    logic              flush_o;
    logic [ADDR_W:0]   count_o;
    logic              err_o;

    modport master (
        output alloc_valid_i, alloc_idx_i, alloc_has_dest_i, alloc_dest_i, stall_i,
        output wb_valid_i, wb_idx_i, wb_data_i, wb_exc_i, head_i, commit_ready_i,
        input  commit_valid_o, commit_has_dest_o, commit_dest_o, commit_data_o,
        input  commit_exc_o, update_head_o, flush_o, count_o, err_o
    );

    modport slave (
        input  alloc_valid_i, alloc_idx_i, alloc_has_dest_i, alloc_dest_i, stall_i,
        input  wb_valid_i, wb_idx_i, wb_data_i, wb_exc_i, head_i, commit_ready_i,
        output commit_valid_o, commit_has_dest_o, commit_dest_o, commit_data_o,
        output commit_exc_o, update_head_o, flush_o, count_o, err_o
    );
endinterface

// File: rtl/rob_entry_table.sv
// rtl/rob_entry_table.sv - ROB entry storage with writeback completion and in-order commit.
import rob_pkg::*;

module rob_entry_table #(
    parameter int ROB_SIZE = ROB_SIZE_DEF,
    parameter int ADDR_W   = $clog2(ROB_SIZE),
    parameter int REG_W    = REG_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    rob_entry_table_if.slave bus
);

    // Entry layout is fixed by rob_pkg, so REG_W/DATA_W must match its defaults.
    rob_entry_t        entries_q [ROB_SIZE];
    rob_entry_t        entries_d [ROB_SIZE];
    logic [ADDR_W:0]   count_q, count_d;
    logic              flush_q, flush_d;
    logic              err_q, err_d;

    rob_entry_t        head_entry;
    logic              commit_valid;
    logic              fire;
    logic              exc_fire;
    logic              alloc_req;
    logic              alloc_conflict;
    logic              alloc_fire;
    logic              wb_hit;
    logic [REG_W-1:0]  alloc_dest;
    logic [DATA_W-1:0] wb_data;

    assign alloc_dest = bus.alloc_dest_i;
    assign wb_data    = bus.wb_data_i;

    always_comb begin
        head_entry   = entries_q[bus.head_i];
        commit_valid = head_entry.valid & head_entry.done;
        fire         = commit_valid & bus.commit_ready_i;
        exc_fire     = fire & head_entry.exc;
        alloc_req    = bus.alloc_valid_i & ~bus.stall_i & ~flush_q;
        // Reusing the slot that is retiring this very cycle is legal, not a collision.
        alloc_conflict = alloc_req & entries_q[bus.alloc_idx_i].valid
                         & ~(fire & (bus.alloc_idx_i == bus.head_i));
        alloc_fire   = alloc_req & ~alloc_conflict & ~exc_fire;
        wb_hit       = bus.wb_valid_i & entries_q[bus.wb_idx_i].valid & ~exc_fire;
    end

    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            entries_d[i] = entries_q[i];
        end
        count_d = count_q;
        flush_d = exc_fire;
        err_d   = err_q | (alloc_conflict & ~exc_fire);

        if (exc_fire) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
            count_d = '0;
        end else begin
            if (wb_hit) begin
                entries_d[bus.wb_idx_i].done = 1'b1;
                entries_d[bus.wb_idx_i].data = wb_data;
                entries_d[bus.wb_idx_i].exc  = bus.wb_exc_i;
            end
            if (fire) begin
                entries_d[bus.head_i].valid = 1'b0;
            end
            // Applied last so a same-slot allocate overrides the commit's clear.
            if (alloc_fire) begin
                entries_d[bus.alloc_idx_i] = entry_alloc(entries_q[bus.alloc_idx_i],
                                                         bus.alloc_has_dest_i, alloc_dest);
            end
            count_d = count_q + {{ADDR_W{1'b0}}, alloc_fire} - {{ADDR_W{1'b0}}, fire};
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    assign bus.commit_valid_o    = commit_valid;
    assign bus.commit_has_dest_o = head_entry.has_dest;
    assign bus.commit_dest_o     = head_entry.dest;
    assign bus.commit_data_o     = head_entry.data;
    assign bus.commit_exc_o      = head_entry.exc;
    assign bus.update_head_o     = fire;
    assign bus.flush_o           = flush_q;
    assign bus.count_o           = count_q;
    assign bus.err_o             = err_q;

endmodule

// File: tb/tb_rob_entry_table.sv
// tb/tb_rob_entry_table.sv - randomized and directed checks of rob_entry_table against an array model.
module tb_rob_entry_table;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_entry_table_if #(.ADDR_W(3), .REG_W(5), .DATA_W(32)) bus ();

    rob_entry_table dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit          m_valid [N];
    bit          m_done  [N];
    bit          m_exc   [N];
    bit          m_hd    [N];
    logic [4:0]  m_dest  [N];
    logic [31:0] m_data  [N];
    int          m_count;
    bit          m_flush;
    bit          m_err;
    int          head;
    int          tail;

    bit          d_av, d_ahd, d_st, d_wv, d_we, d_rdy;
    int          d_aidx, d_adest, d_widx;
    logic [31:0] d_wd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        d_av = 0; d_aidx = 0; d_ahd = 0; d_adest = 0; d_st = 0;
        d_wv = 0; d_widx = 0; d_wd = '0; d_we = 0; d_rdy = 0;
    endtask

    task automatic apply_in();
        bus.alloc_valid_i    = d_av;
        bus.alloc_idx_i      = 3'(d_aidx);
        bus.alloc_has_dest_i = d_ahd;
        bus.alloc_dest_i     = 5'(d_adest);
        bus.stall_i          = d_st;
        bus.wb_valid_i       = d_wv;
        bus.wb_idx_i         = 3'(d_widx);
        bus.wb_data_i        = d_wd;
        bus.wb_exc_i         = d_we;
        bus.head_i           = 3'(head);
        bus.commit_ready_i   = d_rdy;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_done[i] = 0; m_exc[i] = 0; m_hd[i] = 0;
            m_dest[i] = '0; m_data[i] = '0;
        end
        m_count = 0; m_flush = 0; m_err = 0; head = 0; tail = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count", bus.count_o, 0);
        chk("rst_commit_valid", bus.commit_valid_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_flush", bus.flush_o, 0);
        chk("rst_update_head", bus.update_head_o, 0);
        model_reset();
        clear_in();
        apply_in();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive, check outputs against the model, then advance the model.
    task automatic step();
        bit cv, fire, efire, try_a, conflict, acc;
        @(negedge clk);
        apply_in();
        #1;
        cv   = m_valid[head] && m_done[head];
        fire = cv && d_rdy;
        chk("commit_valid", bus.commit_valid_o, cv);
        chk("update_head", bus.update_head_o, fire);
        if (cv) begin
            chk("commit_dest", bus.commit_dest_o, m_dest[head]);
            chk("commit_data", bus.commit_data_o, m_data[head]);
            chk("commit_exc", bus.commit_exc_o, m_exc[head]);
            chk("commit_has_dest", bus.commit_has_dest_o, m_hd[head]);
        end
        chk("count", bus.count_o, m_count);
        chk("flush", bus.flush_o, m_flush);
        chk("err", bus.err_o, m_err);

        efire = fire && m_exc[head];
        try_a = d_av && !d_st && !m_flush;
        if (efire) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_done[i]  = 0;
            end
            m_count = 0;
            m_flush = 1;
            head = 0;
            tail = 0;
        end else begin
            conflict = try_a && m_valid[d_aidx] && !(fire && d_aidx == head);
            acc      = try_a && !conflict;
            if (conflict) m_err = 1;
            if (d_wv && m_valid[d_widx]) begin
                m_done[d_widx] = 1;
                m_data[d_widx] = d_wd;
                m_exc[d_widx]  = d_we;
            end
            if (fire) m_valid[head] = 0;
            if (acc) begin
                m_valid[d_aidx] = 1;
                m_done[d_aidx]  = 0;
                m_exc[d_aidx]   = 0;
                m_hd[d_aidx]    = d_ahd;
                m_dest[d_aidx]  = 5'(d_adest);
            end
            m_count = m_count + int'(acc) - int'(fire);
            m_flush = 0;
            if (fire) head = (head + 1) % N;
            if (acc && d_aidx == tail) tail = (tail + 1) % N;
        end
    endtask

    task automatic alloc(input int idx, input int dest);
        clear_in();
        d_av = 1; d_aidx = idx; d_ahd = 1; d_adest = dest;
        step();
    endtask

    task automatic wb(input int idx, input logic [31:0] data, input bit exc);
        clear_in();
        d_wv = 1; d_widx = idx; d_wd = data; d_we = exc;
        step();
    endtask

    task automatic idle(input bit rdy);
        clear_in();
        d_rdy = rdy;
        step();
    endtask

    initial begin
        model_reset();
        clear_in();
        apply_in();
        do_reset();

        // Basic allocate / writeback / commit
        alloc(0, 3); alloc(1, 4); alloc(2, 5);
        idle(0);
        chk("basic_count3", bus.count_o, 3);
        wb(1, 32'hAA, 0);
        chk("head_not_done", bus.commit_valid_o, 0);
        wb(0, 32'h55, 0);
        chk("no_wb_bypass", bus.commit_valid_o, 0);
        idle(0);
        chk("basic_cv", bus.commit_valid_o, 1);
        chk("basic_dest", bus.commit_dest_o, 3);
        chk("basic_data", bus.commit_data_o, 32'h55);
        idle(1);
        chk("basic_update_head", bus.update_head_o, 1);
        idle(0);
        chk("basic_count2", bus.count_o, 2);

        // Ready back-pressure on head entry 1
        for (int k = 0; k < 3; k++) begin
            idle(0);
            chk("bp_cv", bus.commit_valid_o, 1);
            chk("bp_no_fire", bus.update_head_o, 0);
            chk("bp_count", bus.count_o, 2);
        end
        idle(1);
        chk("bp_fire", bus.update_head_o, 1);
        idle(1);
        chk("bp_single_fire", bus.update_head_o, 0);
        chk("bp_count1", bus.count_o, 1);

        // Conflict on occupied entry 2, then stalled allocate
        alloc(2, 9);
        idle(0);
        chk("conflict_err", bus.err_o, 1);
        chk("conflict_count", bus.count_o, 1);
        wb(2, 32'h77, 0);
        idle(0);
        chk("conflict_dest_kept", bus.commit_dest_o, 5);
        clear_in();
        d_av = 1; d_aidx = tail; d_st = 1; d_adest = 1;
        step();
        idle(0);
        chk("stall_count", bus.count_o, 1);
        chk("err_sticky", bus.err_o, 1);
        idle(1);

        // Mid-run asynchronous reset
        alloc(3, 7);
        do_reset();

        // Exception flush
        alloc(0, 1); alloc(1, 2); alloc(2, 3); alloc(3, 4);
        wb(0, 32'h1, 1);
        clear_in();
        d_rdy = 1; d_av = 1; d_aidx = 4; d_adest = 6;
        step();
        chk("exc_fire", bus.update_head_o, 1);
        alloc(0, 8);
        chk("flush_high", bus.flush_o, 1);
        chk("flush_count", bus.count_o, 0);
        chk("flush_cv", bus.commit_valid_o, 0);
        idle(0);
        chk("flush_one_cycle", bus.flush_o, 0);
        chk("flush_alloc_dropped", bus.count_o, 0);
        alloc(0, 8);
        idle(0);
        chk("post_flush_alloc", bus.count_o, 1);

        // Same-cycle allocate and commit on index 7
        do_reset();
        head = 7; tail = 7;
        alloc(7, 2);
        wb(7, 32'h99, 0);
        clear_in();
        d_rdy = 1; d_av = 1; d_aidx = 7; d_ahd = 1; d_adest = 6;
        step();
        chk("same_fire", bus.update_head_o, 1);
        head = 7;
        idle(0);
        chk("same_not_done", bus.commit_valid_o, 0);
        chk("same_count", bus.count_o, 1);
        chk("same_err", bus.err_o, 0);
        wb(7, 32'h42, 0);
        idle(0);
        chk("same_new_dest", bus.commit_dest_o, 6);
        chk("same_new_data", bus.commit_data_o, 32'h42);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            clear_in();
            d_av    = bit'($urandom_range(0, 1));
            d_aidx  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, N - 1)) : tail;
            d_ahd   = bit'($urandom_range(0, 1));
            d_adest = int'($urandom_range(0, 31));
            d_st    = (m_count == N) || ($urandom_range(0, 7) == 0);
            d_wv    = bit'($urandom_range(0, 1));
            d_widx  = int'($urandom_range(0, N - 1));
            d_wd    = $urandom;
            d_we    = ($urandom_range(0, 11) == 0);
            d_rdy   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
